// File: rtl/touch_key_filter.sv
// Touch-key conditioner: 2-flop synchroniser, debounce counter and press/release/long-press FSM.
// Define TOUCH_LONG_PRESS_EN to build the hold counter, LONG state and key_long pulse.
module touch_key_filter #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_touch_key,
    output logic o_key_flag,
    output logic o_key_rel,
    output logic o_key_long,
    output logic o_key_state
);

    localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_deb_cnt;
    logic        r_key_state;
    logic        r_key_flag;
    logic        r_key_rel;

    logic w_touched;
    logic w_mismatch;
    logic w_deb_done;
    logic w_press;
    logic w_release;

    // Synchroniser idles high so reset never looks like a touch.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_touch_key;
            r_sync2 <= r_sync1;
        end
    end

    assign w_touched  = ~r_sync2;
    assign w_mismatch = w_touched ^ r_key_state;
    assign w_deb_done = w_mismatch && (r_deb_cnt == CNT_LAST);
    assign w_press    = w_deb_done & ~r_key_state;
    assign w_release  = w_deb_done & r_key_state;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_deb_cnt   <= 20'd0;
            r_key_state <= 1'b0;
        end else if (!w_mismatch) begin
            r_deb_cnt <= 20'd0;
        end else if (w_deb_done) begin
            r_deb_cnt   <= 20'd0;
            r_key_state <= ~r_key_state;
        end else begin
            r_deb_cnt <= r_deb_cnt + 20'd1;
        end
    end

`ifdef TOUCH_LONG_PRESS_EN
    localparam logic [25:0] LONG_LAST = LONG_MAX - 26'd1;

    typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [25:0] r_hold_cnt;
    logic [25:0] w_hold_d;
    logic        r_key_long;
    logic        w_flag_d;
    logic        w_rel_d;
    logic        w_long_d;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state    <= StIdle;
            r_hold_cnt <= 26'd0;
            r_key_flag <= 1'b0;
            r_key_rel  <= 1'b0;
            r_key_long <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_d;
            r_key_flag <= w_flag_d;
            r_key_rel  <= w_rel_d;
            r_key_long <= w_long_d;
        end
    end

    // Release is tested before the long-press threshold so it wins a same-cycle tie.
    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold_cnt;
        w_flag_d  = 1'b0;
        w_rel_d   = 1'b0;
        w_long_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_press) begin
                    w_state_d = StPressed;
                    w_flag_d  = 1'b1;
                    w_hold_d  = 26'd0;
                end
            end
            StPressed: begin
                w_hold_d = r_hold_cnt + 26'd1;
                if (w_release) begin
                    w_state_d = StIdle;
                    w_rel_d   = 1'b1;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_state_d = StLong;
                    w_long_d  = 1'b1;
                end
            end
            StLong: begin
                if (w_release) begin
                    w_state_d = StIdle;
                    w_rel_d   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_key_long = r_key_long;
`else
    typedef enum logic [0:0] {StIdle, StPressed} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        w_flag_d;
    logic        w_rel_d;
    logic [25:0] w_unused_long_max;

    assign w_unused_long_max = LONG_MAX;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state    <= StIdle;
            r_key_flag <= 1'b0;
            r_key_rel  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_key_flag <= w_flag_d;
            r_key_rel  <= w_rel_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_flag_d  = 1'b0;
        w_rel_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_press) begin
                    w_state_d = StPressed;
                    w_flag_d  = 1'b1;
                end
            end
            StPressed: begin
                if (w_release) begin
                    w_state_d = StIdle;
                    w_rel_d   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_key_long = 1'b0;
`endif

    assign o_key_flag  = r_key_flag;
    assign o_key_rel   = r_key_rel;
    assign o_key_state = r_key_state;

endmodule

// File: tb/tb_touch_key_filter.sv
// Directed bench for touch_key_filter with CNT_MAX=10, LONG_MAX=50; key_long expectations
// follow the TOUCH_LONG_PRESS_EN define.
module tb_touch_key_filter;

    logic clk = 1'b0;
    logic rst;
    logic touch;
    logic key_flag;
    logic key_rel;
    logic key_long;
    logic key_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int n_flag, n_rel, n_long;
    int flag_cyc, rel_cyc, long_cyc;
    int n_excl = 0;

`ifdef TOUCH_LONG_PRESS_EN
    localparam int LongExp = 1;
`else
    localparam int LongExp = 0;
`endif

    touch_key_filter #(
        .CNT_MAX (20'd10),
        .LONG_MAX(26'd50)
    ) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_touch_key(touch),
        .o_key_flag (key_flag),
        .o_key_rel  (key_rel),
        .o_key_long (key_long),
        .o_key_state(key_state)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (key_flag === 1'b1) begin
            n_flag++;
            flag_cyc = cyc;
        end
        if (key_rel === 1'b1) begin
            n_rel++;
            rel_cyc = cyc;
        end
        if (key_long === 1'b1) begin
            n_long++;
            long_cyc = cyc;
        end
        if ((int'(key_flag === 1'b1) + int'(key_rel === 1'b1) + int'(key_long === 1'b1)) > 1)
            n_excl++;
    end

    task automatic clear_counts();
        n_flag = 0;
        n_rel = 0;
        n_long = 0;
        flag_cyc = -1;
        rel_cyc = -1;
        long_cyc = -1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        touch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({key_flag, key_rel, key_long, key_state} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b required 0000",
                         {key_flag, key_rel, key_long, key_state});
            end
        end
        #1;
        clear_counts();
        c = cyc;
        rst = 1'b0;
        wait_cyc(20);
        checks++;
        if (n_flag !== 1) begin
            errors++;
            $display("FAIL reset_flag_count: got %0d required 1", n_flag);
        end
        checks++;
        if (flag_cyc !== c + 12) begin
            errors++;
            $display("FAIL reset_flag_latency: got %0d required %0d", flag_cyc - c, 12);
        end
        touch = 1'b1;
        wait_cyc(20);
        checks++;
        if (key_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_state: got %b required 0", key_state);
        end
    endtask

    task automatic test_clean_press();
        int c0, c1;
        clear_counts();
        c0 = cyc;
        touch = 1'b0;
        wait_cyc(100);
        checks++;
        if (key_state !== 1'b1) begin
            errors++;
            $display("FAIL clean_state_held: got %b required 1", key_state);
        end
        c1 = cyc;
        touch = 1'b1;
        wait_cyc(20);
        checks++;
        if (n_flag !== 1 || flag_cyc !== c0 + 12) begin
            errors++;
            $display("FAIL clean_flag: got count %0d at +%0d required 1 at +12", n_flag,
                     flag_cyc - c0);
        end
        checks++;
        if (n_long !== LongExp) begin
            errors++;
            $display("FAIL clean_long_count: got %0d required %0d", n_long, LongExp);
        end
`ifdef TOUCH_LONG_PRESS_EN
        checks++;
        if (long_cyc !== flag_cyc + 50) begin
            errors++;
            $display("FAIL clean_long_latency: got %0d required 50", long_cyc - flag_cyc);
        end
`endif
        checks++;
        if (n_rel !== 1 || rel_cyc !== c1 + 12) begin
            errors++;
            $display("FAIL clean_rel: got count %0d at +%0d required 1 at +12", n_rel,
                     rel_cyc - c1);
        end
        checks++;
        if (key_state !== 1'b0) begin
            errors++;
            $display("FAIL clean_state_released: got %b required 0", key_state);
        end
    endtask

    task automatic test_bounce();
        int c1;
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            touch = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_cyc(3);
        end
        checks++;
        if (n_flag + n_rel + n_long !== 0 || key_state !== 1'b0) begin
            errors++;
            $display("FAIL bounce_quiet: got pulses %0d state %b required 0 and 0",
                     n_flag + n_rel + n_long, key_state);
        end
        c1 = cyc;
        touch = 1'b0;
        wait_cyc(20);
        checks++;
        if (n_flag !== 1 || flag_cyc !== c1 + 12) begin
            errors++;
            $display("FAIL bounce_flag: got count %0d at +%0d required 1 at +12", n_flag,
                     flag_cyc - c1);
        end
        touch = 1'b1;
        wait_cyc(20);
        checks++;
        if (n_rel !== 1) begin
            errors++;
            $display("FAIL bounce_rel_count: got %0d required 1", n_rel);
        end
    endtask

    task automatic test_short_press();
        int c0;
        wait_cyc(5);
        clear_counts();
        c0 = cyc;
        touch = 1'b0;
        wait_cyc(50);
        touch = 1'b1;
        wait_cyc(20);
        checks++;
        if (n_flag !== 1 || flag_cyc !== c0 + 12) begin
            errors++;
            $display("FAIL short_flag: got count %0d at +%0d required 1 at +12", n_flag,
                     flag_cyc - c0);
        end
        checks++;
        if (n_rel !== 1 || rel_cyc !== c0 + 62) begin
            errors++;
            $display("FAIL short_rel: got count %0d at +%0d required 1 at +62", n_rel,
                     rel_cyc - c0);
        end
        checks++;
        if (n_long !== 0) begin
            errors++;
            $display("FAIL short_no_long: got %0d required 0", n_long);
        end
    endtask

    task automatic test_mid_press_reset();
        int c0, c2;
        clear_counts();
        c0 = cyc;
        touch = 1'b0;
        wait_cyc(20);
        checks++;
        if (key_state !== 1'b1 || flag_cyc !== c0 + 12) begin
            errors++;
            $display("FAIL midrst_pre: got state %b flag +%0d required 1 and +12", key_state,
                     flag_cyc - c0);
        end
        clear_counts();
        rst = 1'b1;
        #1;
        checks++;
        if ({key_flag, key_rel, key_long, key_state} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear: got %b required 0000",
                     {key_flag, key_rel, key_long, key_state});
        end
        wait_cyc(5);
        c2 = cyc;
        rst = 1'b0;
        wait_cyc(20);
        checks++;
        if (n_rel !== 0) begin
            errors++;
            $display("FAIL midrst_no_rel: got %0d required 0", n_rel);
        end
        checks++;
        if (n_flag !== 1 || flag_cyc !== c2 + 12) begin
            errors++;
            $display("FAIL midrst_flag: got count %0d at +%0d required 1 at +12", n_flag,
                     flag_cyc - c2);
        end
        touch = 1'b1;
        wait_cyc(20);
        checks++;
        if (n_rel !== 1 || key_state !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: got rel %0d state %b required 1 and 0", n_rel,
                     key_state);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_excl !== 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles required 0", n_excl);
        end
    endtask

    initial begin
        rst = 1'b1;
        touch = 1'b1;
        clear_counts();
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_mid_press_reset();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/touch_key_filter.md
# touch_key_filter

Conditioning stage that sits directly upstream of the touch-key LED toggle logic. It synchronises the raw, active-low touch sensor input, debounces it, and emits single-cycle press/release pulses plus a debounced level. The LED control stage consumes `key_flag` instead of sampling `touch_key` directly. An optional long-press detector is also provided.

## Interface
- `CNT_MAX`, default 20'd999_999: debounce length in `sys_clk` cycles (20 ms at 50 MHz); legal range 2 to 2^20-1.
- `LONG_MAX`, default 26'd49_999_999: hold time, in cycles after `key_flag`, before `key_long` fires (1 s at 50 MHz); legal range 2 to 2^26-1.
- `sys_clk` input 1: system clock; all logic is on the rising edge.
- `sys_rst` input 1: reset, asynchronous, active-high.
- `touch_key` input 1: raw touch sensor; 1 = idle, 0 = touched; asynchronous to `sys_clk`.
- `key_flag` output 1: one-cycle pulse on a debounced press.
- `key_rel` output 1: one-cycle pulse on a debounced release.
- `key_long` output 1: one-cycle pulse when a press has been held `LONG_MAX` cycles.
- `key_state` output 1: debounced level; 1 = touched.

## Operation
- **Synchroniser:** two flops, both reset to 1 (the idle level). The second flop's output is `key_sync`.
- **Debounce counter `deb_cnt`:** 20 bits, reset 0.
  - Clears to 0 on any cycle where the touched sense of `key_sync` equals `key_state`.
  - Otherwise increments.
  - If it already holds `CNT_MAX-1` and the mismatch persists, `key_state` toggles on that edge and `deb_cnt` clears.
- **FSM, 3 states, reset to IDLE:**
  - IDLE -> PRESSED when `key_state` goes 0->1. `key_flag`=1 for that one cycle, and `hold_cnt` clears.
  - PRESSED -> LONG when `hold_cnt` reaches `LONG_MAX-1`. `key_long`=1 for one cycle. `hold_cnt` increments every cycle while in PRESSED.
  - PRESSED or LONG -> IDLE when `key_state` goes 1->0. `key_rel`=1 for one cycle.
  - In LONG, `hold_cnt` freezes. A held key produces no repeat `key_long`.
- **Glitch rejection:** a touch or release shorter than `CNT_MAX` synchronised cycles resets `deb_cnt` and produces no pulse and no level change.
- **Pulse exclusivity:** `key_flag`, `key_rel` and `key_long` are never high in the same cycle. A release on the cycle `hold_cnt` reaches `LONG_MAX-1` takes priority: `key_rel` fires and `key_long` does not.
- **Registered outputs:** every output is driven directly by a flop; there is no combinational path from `touch_key`.

## Timing
- **Reset values:** `key_flag`=0, `key_rel`=0, `key_long`=0, `key_state`=0, FSM=IDLE, both counters 0, synchroniser flops =1.
- **Reset mid-operation:** all state clears immediately. A key still held after `sys_rst` deasserts is treated as a new press, and `key_flag` follows after full latency.
- **Press latency:** `touch_key` stable low before rising edge e0 -> `key_state`=1 and `key_flag`=1 in the cycle after edge e(CNT_MAX+1), i.e. CNT_MAX+2 cycles.
- **Release latency:** identical to press latency, with `key_rel` in place of `key_flag`.
- **Long-press timing:** `key_long` asserts exactly `LONG_MAX` cycles after the `key_flag` cycle.
- **Minimum spacing:** back-to-back qualified events are at least `CNT_MAX` cycles apart, so pulses never merge.

## Configuration
- **`TOUCH_LONG_PRESS_EN` defined:**
  - `hold_cnt` and the LONG state are compiled in.
  - `key_long` behaves as specified above.
- **`TOUCH_LONG_PRESS_EN` undefined:**
  - No `hold_cnt` and no LONG state; the FSM is IDLE/PRESSED only.
  - `key_long` is tied to 0.
  - `LONG_MAX` is accepted but unused.
  - `key_flag`, `key_rel` and `key_state` behaviour is unchanged.

## Test plan
Bench settings: 20 ns clock, `CNT_MAX`=10, `LONG_MAX`=50; reset high for 200 ns.
- **Reset:** `sys_rst` high with `touch_key`=0 -> all outputs 0 throughout reset. After release, `key_flag` pulses once 12 cycles later.
- **Clean press:** `touch_key` low for 2000 ns (100 cycles), then high ->
  - one `key_flag` 12 cycles after the fall;
  - `key_long` exactly 50 cycles after `key_flag` (macro defined);
  - one `key_rel` 12 cycles after the rise.
- **Bounce:** `touch_key` toggles with 60 ns periods (3 cycles) for 600 ns, then stays low -> no pulses during the bounce, and a single `key_flag` 12 cycles after the final fall.
- **Short press:** low for 1000 ns, then high ->
  - `key_flag` and `key_rel` each exactly once;
  - no `key_long`, because the press lasted about 50 cycles from `key_flag` to release and `key_rel` takes priority at the boundary.
- **Macro off:** repeat the clean-press scenario with `TOUCH_LONG_PRESS_EN` undefined -> `key_long` stays 0; `key_flag` and `key_rel` timing is identical to the clean-press case.
- **Mid-press reset:** assert `sys_rst` 20 cycles into a held press -> outputs clear immediately and no `key_rel` is generated. After deassertion, a fresh `key_flag` follows 12 cycles later.
